// File: rtl/minsec_pkg.sv
// Shared types and constants for the min:sec stopwatch core.
package minsec_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_L_MAX = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_H_MAX = 4'd5;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  // Next value of a digit that wraps to zero after max; any code above max
  // (unreachable in normal operation) also recovers to zero.
  function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
    return (d >= max) ? '0 : bcd_t'(d + bcd_t'(1));
  endfunction

endpackage

// File: rtl/bcd_mod60_cnt.sv
// Two-digit BCD counter 00..59 with a combinational wrap strobe.
module bcd_mod60_cnt
  import minsec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] hi,
  output logic [3:0] lo,
  output logic       carry_out
);

  bcd_t hi_q, lo_q;
  logic lo_wrap;

  assign lo_wrap = (lo_q >= DIGIT_L_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (inc) begin
      lo_q <= bcd_next(lo_q, DIGIT_L_MAX);
      if (hi_q > DIGIT_H_MAX) begin
        hi_q <= '0;
      end else if (lo_wrap) begin
        hi_q <= bcd_next(hi_q, DIGIT_H_MAX);
      end
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign carry_out = inc & (hi_q == DIGIT_H_MAX) & (lo_q == DIGIT_L_MAX);

endmodule

// File: rtl/min_sec_counter.sv
// Stopwatch core: run/pause flag, clear, and cascaded seconds/minutes counters.
// Define MINSEC_PRESCALE_EN to divide the clock by CLK_DIV for the second tick.
module min_sec_counter
  import minsec_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start_stop,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic       add_min_l,
  output logic       add_hour_l
);

  run_state_t state_q, state_d;
  logic       run;
  logic       tick;
  logic       sec_inc;

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = STOP;
    end else if (start_stop) begin
      state_d = (state_q == RUN) ? STOP : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == RUN);

`ifdef MINSEC_PRESCALE_EN
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q;

  assign tick = (presc_q == PW'(CLK_DIV - 1));

  // Prescaler phase restarts whenever the stopwatch leaves RUN.
  always_ff @(posedge clk) begin
    if (rst || state_d == STOP) begin
      presc_q <= '0;
    end else if (run) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end
`else
  // Every legal divider is positive, so this is a constant one-per-cycle tick.
  assign tick = (CLK_DIV > 0);
`endif

  // The carries must stay low in the cycle reset or clear is applied.
  assign sec_inc = run & tick & ~rst & ~clear;

  bcd_mod60_cnt u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (sec_inc),
    .clr       (clear),
    .hi        (sec_h),
    .lo        (sec_l),
    .carry_out (add_min_l)
  );

  bcd_mod60_cnt u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (add_min_l),
    .clr       (clear),
    .hi        (min_h),
    .lo        (min_l),
    .carry_out (add_hour_l)
  );

endmodule

// File: tb/tb_min_sec_counter.sv
// Self-checking bench for min_sec_counter (default build, tick every cycle).
module tb_min_sec_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       start_stop = 1'b0;
  logic [3:0] sec_h, sec_l, min_h, min_l;
  logic       add_min_l, add_hour_l;
  logic [15:0] digits;

  int total = 0;
  int bad   = 0;

  // Reference model: running flag plus plain integer minutes and seconds.
  bit m_run = 1'b0;
  int m_sec = 0;
  int m_min = 0;
  bit m_amin, m_ahour;
  logic obs_amin, obs_ahour;

  min_sec_counter dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .start_stop (start_stop),
    .sec_h      (sec_h),
    .sec_l      (sec_l),
    .min_h      (min_h),
    .min_l      (min_l),
    .add_min_l  (add_min_l),
    .add_hour_l (add_hour_l)
  );

  always #5 clk = ~clk;

  assign digits = {min_h, min_l, sec_h, sec_l};

  function automatic logic [15:0] exp_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  // One clock: apply inputs, predict carries, sample carries mid-cycle,
  // advance the model on the edge, then release the pulses.
  task automatic do_cycle(input bit r, input bit c, input bit s);
    int t;
    rst = r; clear = c; start_stop = s;
    m_amin  = !r && !c && m_run && (m_sec == 59);
    m_ahour = m_amin && (m_min == 59);
    @(negedge clk);
    obs_amin  = add_min_l;
    obs_ahour = add_hour_l;
    @(posedge clk);
    if (r || c) begin
      m_run = 1'b0; m_sec = 0; m_min = 0;
    end else begin
      if (m_run) begin
        t = (m_min * 60 + m_sec + 1) % 3600;
        m_sec = t % 60;
        m_min = t / 60;
      end
      if (s) m_run = !m_run;
    end
    #1;
    rst = 1'b0; clear = 1'b0; start_stop = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (digits !== 16'h0000 || obs_amin !== 1'b0 || obs_ahour !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b%b want=0000/00", digits, obs_amin, obs_ahour);
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (digits !== 16'h0000 || obs_amin !== 1'b0 || obs_ahour !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%h/%b%b want=0000/00", i, digits, obs_amin, obs_ahour);
      end
    end
  endtask

  task automatic test_start_and_minute();
    do_cycle(1'b0, 1'b0, 1'b1);
    total++;
    if (digits !== 16'h0000) begin
      bad++;
      $display("FAIL start_latch got=%h want=0000", digits);
    end
    do_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (digits !== 16'h0001) begin
      bad++;
      $display("FAIL first_inc got=%h want=0001", digits);
    end
    for (int i = 0; i < 58; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (digits !== exp_digits() || obs_amin !== m_amin) begin
        bad++;
        $display("FAIL sec_count cyc=%0d got=%h/%b want=%h/%b", i, digits, obs_amin, exp_digits(), m_amin);
      end
    end
    do_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (obs_amin !== 1'b1 || obs_ahour !== 1'b0 || digits !== 16'h0100) begin
      bad++;
      $display("FAIL sec_wrap got=%h/%b%b want=0100/10", digits, obs_amin, obs_ahour);
    end
    do_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (obs_amin !== 1'b0 || digits !== 16'h0101) begin
      bad++;
      $display("FAIL carry_width got=%h/%b want=0101/0", digits, obs_amin);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 100; i++) do_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (digits !== exp_digits()) begin
      bad++;
      $display("FAIL run_100 got=%h want=%h", digits, exp_digits());
    end
    do_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (digits !== 16'h0000 || obs_amin !== 1'b0) begin
        bad++;
        $display("FAIL clear_hold cyc=%0d got=%h/%b want=0000/0", i, digits, obs_amin);
      end
      do_cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_pause();
    logic [15:0] resume_exp [4] = '{16'h0007, 16'h0008, 16'h0009, 16'h0010};
    int n = 0;
    do_cycle(1'b0, 1'b0, 1'b1);
    while (m_sec != 6 && n < 20) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (digits !== 16'h0006) begin
      bad++;
      $display("FAIL pause_pre got=%h want=0006", digits);
    end
    do_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (digits !== 16'h0007) begin
        bad++;
        $display("FAIL pause_hold cyc=%0d got=%h want=0007", i, digits);
      end
      do_cycle(1'b0, 1'b0, 1'b0);
    end
    do_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (digits !== resume_exp[i]) begin
        bad++;
        $display("FAIL resume step=%0d got=%h want=%h", i, digits, resume_exp[i]);
      end
      if (i < 3) do_cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_hour_wrap();
    int min_pulses = 0;
    int hour_idx   = -1;
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3600; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      if (obs_amin === 1'b1) min_pulses++;
      if (obs_ahour === 1'b1) hour_idx = i;
      if (obs_amin !== m_amin || obs_ahour !== m_ahour) begin
        total++;
        bad++;
        $display("FAIL hour_carry cyc=%0d got=%b%b want=%b%b", i, obs_amin, obs_ahour, m_amin, m_ahour);
      end
    end
    total++;
    if (hour_idx != 3599 || min_pulses != 60) begin
      bad++;
      $display("FAIL hour_wrap idx=%0d pulses=%0d want idx=3599 pulses=60", hour_idx, min_pulses);
    end
    total++;
    if (digits !== 16'h0000) begin
      bad++;
      $display("FAIL hour_zero got=%h want=0000", digits);
    end
  endtask

  task automatic test_clear_with_start();
    int n = int'($urandom_range(5, 50));
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (digits !== 16'h0000 || m_run) begin
        bad++;
        $display("FAIL clear_prio cyc=%0d got=%h want=0000", i, digits);
      end
      do_cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    bit r, c, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 127) == 0);
      c = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 15) == 0);
      do_cycle(r, c, s);
      total++;
      if (digits !== exp_digits() || obs_amin !== m_amin || obs_ahour !== m_ahour) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h/%b%b want=%h/%b%b",
                 i, digits, obs_amin, obs_ahour, exp_digits(), m_amin, m_ahour);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_and_minute();
    test_clear();
    test_pause();
    test_hour_wrap();
    test_clear_with_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
